// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the M-extension multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } func3_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_sign_ctl.sv
// rtl/muldiv_sign_ctl.sv - operand magnitudes, result sign and fast-path detection
module muldiv_sign_ctl
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int WORD_LENGTH = 32
) (
    input  func3_t                func3,
    input  logic                  is_word,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic [DATA_WIDTH-1:0] data2,
    output logic [DATA_WIDTH-1:0] mag1,
    output logic [DATA_WIDTH-1:0] mag2,
    output logic                  neg_res,
    output logic                  fast,
    output logic [DATA_WIDTH-1:0] fast_res
);

    localparam logic [WORD_LENGTH-1:0] WORD_MIN = {1'b1, {(WORD_LENGTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]  DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] sext_w(input logic [WORD_LENGTH-1:0] v);
        return {{(DATA_WIDTH-WORD_LENGTH){v[WORD_LENGTH-1]}}, v};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext_w(input logic [WORD_LENGTH-1:0] v);
        return {{(DATA_WIDTH-WORD_LENGTH){1'b0}}, v};
    endfunction

    logic                  s1, s2, neg1, neg2, is_div;
    logic                  div_zero, div_ovf, no_word_form;
    logic [DATA_WIDTH-1:0] ext1, ext2, word1;

    always_comb begin
        s1     = func3 inside {MULH, MULHSU, DIV, REM};
        s2     = func3 inside {MULH, DIV, REM};
        is_div = func3 inside {DIV, DIVU, REM, REMU};
        word1  = sext_w(data1[WORD_LENGTH-1:0]);

        ext1 = !is_word ? data1 : (s1 ? word1 : zext_w(data1[WORD_LENGTH-1:0]));
        ext2 = !is_word ? data2 : (s2 ? sext_w(data2[WORD_LENGTH-1:0])
                                      : zext_w(data2[WORD_LENGTH-1:0]));
        neg1 = s1 && ext1[DATA_WIDTH-1];
        neg2 = s2 && ext2[DATA_WIDTH-1];
        mag1 = neg1 ? -ext1 : ext1;
        mag2 = neg2 ? -ext2 : ext2;

        // Remainder follows the dividend; products and quotients follow the sign product.
        neg_res = (func3 == REM) ? neg1 : (neg1 ^ neg2);

        div_zero = is_word ? (data2[WORD_LENGTH-1:0] == '0) : (data2 == '0);
        div_ovf  = (func3 inside {DIV, REM}) &&
                   (is_word ? ((data1[WORD_LENGTH-1:0] == WORD_MIN) && (&data2[WORD_LENGTH-1:0]))
                            : ((data1 == DATA_MIN) && (&data2)));
        no_word_form = is_word && (func3 inside {MULH, MULHSU, MULHU});

        fast     = no_word_form || (is_div && (div_zero || div_ovf));
        fast_res = '0;
        if (no_word_form) begin
            fast_res = '0;
        end else if (div_zero) begin
            fast_res = (func3 inside {DIV, DIVU}) ? '1 : (is_word ? word1 : data1);
        end else if (div_ovf) begin
            fast_res = (func3 == DIV) ? (is_word ? word1 : data1) : '0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide unit with tagged valid/ready result port
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int WORD_LENGTH = 32,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_func3,
    input  logic                  in_is_word,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_res,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int AW = 2 * DATA_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] sext_w(input logic [WORD_LENGTH-1:0] v);
        return {{(DATA_WIDTH-WORD_LENGTH){v[WORD_LENGTH-1]}}, v};
    endfunction

    state_t                state;
    func3_t                op_func3;
    logic                  op_word, op_neg;
    logic [CW-1:0]         cnt;
    logic [AW-1:0]         acc, acc_step;
    logic [DATA_WIDTH-1:0] opnd;

    func3_t                req_func3;
    logic [DATA_WIDTH-1:0] mag1, mag2, fast_res, dividend_init;
    logic                  neg_res, fast;

    assign req_func3 = func3_t'(in_func3);

    muldiv_sign_ctl #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WORD_LENGTH (WORD_LENGTH)
    ) u_sign_ctl (
        .func3    (req_func3),
        .is_word  (in_is_word),
        .data1    (in_data1),
        .data2    (in_data2),
        .mag1     (mag1),
        .mag2     (mag2),
        .neg_res  (neg_res),
        .fast     (fast),
        .fast_res (fast_res)
    );

    // Word divides run WORD_LENGTH steps, so the dividend starts left-aligned.
    assign dividend_init = in_is_word ? (mag1 << (DATA_WIDTH - WORD_LENGTH)) : mag1;

    // acc is {remainder, quotient} for divides and {product high, multiplier} for multiplies.
    logic [DATA_WIDTH:0] rem_shift, trial, sum_add;

    always_comb begin
        rem_shift = '0;
        trial     = '0;
        sum_add   = '0;
        if (op_func3[2]) begin
            rem_shift = acc[AW-1:DATA_WIDTH-1];
            trial     = rem_shift - {1'b0, opnd};
            if (!trial[DATA_WIDTH]) begin
                acc_step = {trial[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_shift[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            sum_add  = {1'b0, acc[AW-1:DATA_WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_step = {sum_add, acc[DATA_WIDTH-1:1]};
        end
    end

    logic [AW-1:0]         prod;
    logic [DATA_WIDTH-1:0] quo, rem, final_res;
    logic [CW-1:0]         last_cnt;

    always_comb begin
        prod = op_neg ? -acc_step : acc_step;
        quo  = op_neg ? -acc_step[DATA_WIDTH-1:0] : acc_step[DATA_WIDTH-1:0];
        rem  = op_neg ? -acc_step[AW-1:DATA_WIDTH] : acc_step[AW-1:DATA_WIDTH];
        case (op_func3)
            // Word multiply leaves the product DATA_WIDTH-WORD_LENGTH bits above bit 0.
            MUL:                 final_res = op_word ? sext_w(acc_step[DATA_WIDTH-WORD_LENGTH +: WORD_LENGTH])
                                                     : prod[DATA_WIDTH-1:0];
            MULH, MULHSU, MULHU: final_res = prod[AW-1:DATA_WIDTH];
            DIV, DIVU:           final_res = op_word ? sext_w(quo[WORD_LENGTH-1:0]) : quo;
            default:             final_res = op_word ? sext_w(rem[WORD_LENGTH-1:0]) : rem;
        endcase
        last_cnt = op_word ? CW'(WORD_LENGTH - 1) : CW'(DATA_WIDTH - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_func3  <= MUL;
            op_word   <= 1'b0;
            op_neg    <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_func3 <= req_func3;
                        op_word  <= in_is_word;
                        op_neg   <= neg_res;
                        out_tag  <= in_tag;
                        cnt      <= '0;
                        opnd     <= in_func3[2] ? mag2 : mag1;
                        acc      <= in_func3[2] ? {{DATA_WIDTH{1'b0}}, dividend_init}
                                                : {{DATA_WIDTH{1'b0}}, mag2};
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        if (fast) begin
                            out_res   <= fast_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                    if (cnt == last_cnt) begin
                        out_res   <= final_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_func3 = '0;
    logic        in_is_word = 1'b0;
    logic [63:0] in_data1 = '0;
    logic [63:0] in_data2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_res;
    logic [4:0]  out_tag;
    logic        busy;

    muldiv_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func3   (in_func3),
        .in_is_word (in_is_word),
        .in_data1   (in_data1),
        .in_data2   (in_data2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [31:0]  a32, b32;
        longint       sa, sb;
        int           sa32, sb32;
        a32 = a[31:0]; b32 = b[31:0];
        sa = a; sb = b; sa32 = a32; sb32 = b32;
        if (w) begin
            case (f)
                F_MUL:  return sx(a32 * b32);
                F_DIV:  if (b32 == 0) return '1;
                        else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx(a32);
                        else return sx(sa32 / sb32);
                F_DIVU: if (b32 == 0) return '1; else return sx(a32 / b32);
                F_REM:  if (b32 == 0) return sx(a32);
                        else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
                        else return sx(sa32 % sb32);
                F_REMU: if (b32 == 0) return sx(a32); else return sx(a32 % b32);
                default: return 64'd0;
            endcase
        end
        case (f)
            F_MUL: return a * b;
            F_MULH, F_MULHSU, F_MULHU: begin
                pa = (f != F_MULHU) ? {{64{a[63]}}, a} : {64'd0, a};
                pb = (f == F_MULH)  ? {{64{b[63]}}, b} : {64'd0, b};
                p  = pa * pb;
                return p[127:64];
            end
            F_DIV:  if (b == 0) return '1;
                    else if (a == MIN64 && b == '1) return a;
                    else return sa / sb;
            F_DIVU: if (b == 0) return '1; else return a / b;
            F_REM:  if (b == 0) return a;
                    else if (a == MIN64 && b == '1) return 64'd0;
                    else return sa % sb;
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        if (w && (f == F_MULH || f == F_MULHSU || f == F_MULHU)) return 1;
        if (f[2]) begin
            if (w ? (b[31:0] == 0) : (b == 0)) return 1;
            if ((f == F_DIV || f == F_REM) &&
                (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN64 && b == '1)))
                return 1;
        end
        return w ? 33 : 65;
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                check(out_res === exp_q[0].res, "out_res", out_res, exp_q[0].res);
                check(out_tag === exp_q[0].tag, "out_tag", {59'd0, out_tag}, {59'd0, exp_q[0].tag});
                check(in_ready === 1'b0, "in_ready_done", {63'd0, in_ready}, 64'd0);
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t);
        exp_t e;
        in_valid = 1'b1; in_func3 = f; in_is_word = w;
        in_data1 = a; in_data2 = b; in_tag = t;
        @(negedge clk);
        check(in_ready === 1'b1, "in_ready_idle", {63'd0, in_ready}, 64'd1);
        e.res = model(f, w, a, b);
        e.tag = t;
        exp_q.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] t, input int hold);
        int lat, n;
        out_ready = (hold == 0);
        send(f, w, a, b, t);
        wait_valid(lat);
        check(lat == exp_latency(f, w, a, b), "latency", 64'(lat), 64'(exp_latency(f, w, a, b)));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            step();
            out_ready = 1'b1;
        end
        n = 0;
        while (out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(out_valid === 1'b0, "handshake", {63'd0, out_valid}, 64'd0);
        step();
    endtask

    task automatic pin(input string name, input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] req);
        check(model(f, w, a, b) === req, name, model(f, w, a, b), req);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 8))
            0: return 64'd0;
            1: return '1;
            2: return MIN64;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'h0000_0000_FFFF_FFFF;
            5: return 64'($urandom_range(0, 20));
            6: return {$urandom, 32'd0};
            7: return sx($urandom);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int lat;
        logic [2:0]  f;
        logic        w;
        logic [63:0] a, b;

        pin("pin_mul", F_MUL, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB);
        pin("pin_mulh", F_MULH, 1'b0, MIN64, MIN64, 64'h4000_0000_0000_0000);
        pin("pin_mulhu", F_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        pin("pin_mulhsu", F_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        pin("pin_div", F_DIV, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        pin("pin_rem", F_REM, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        pin("pin_divu0", F_DIVU, 1'b0, 64'd100, 64'd0, '1);
        pin("pin_rem_ovf", F_REM, 1'b0, MIN64, '1, 64'd0);
        pin("pin_divuw", F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        pin("pin_mulw", F_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);

        repeat (2) @(negedge clk);
        check(out_valid === 1'b0, "reset_out_valid", {63'd0, out_valid}, 64'd0);
        check(busy === 1'b0, "reset_busy", {63'd0, busy}, 64'd0);
        check(out_res === 64'd0, "reset_out_res", out_res, 64'd0);
        check(out_tag === 5'd0, "reset_out_tag", {59'd0, out_tag}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check(in_ready === 1'b1, "ready_after_reset", {63'd0, in_ready}, 64'd1);

        run(F_MUL, 1'b0, 64'd7, -64'sd3, 5'h0A, 0);
        run(F_MULH, 1'b0, MIN64, MIN64, 5'h01, 0);
        run(F_MULHU, 1'b0, '1, '1, 5'h02, 0);
        run(F_MULHSU, 1'b0, '1, 64'd2, 5'h03, 0);
        run(F_DIV, 1'b0, -64'sd7, 64'd2, 5'h04, 0);
        run(F_REM, 1'b0, -64'sd7, 64'd2, 5'h05, 0);
        run(F_DIVU, 1'b0, 64'd100, 64'd0, 5'h06, 0);
        run(F_REM, 1'b0, MIN64, '1, 5'h07, 0);
        run(F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'h08, 0);
        run(F_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'h09, 0);
        run(F_MULH, 1'b1, 64'd5, 64'd6, 5'h0B, 0);
        run(F_DIV, 1'b0, 64'd1234567, 64'd89, 5'h0C, 10);

        // Flush mid-iteration: nothing may come out, and the next request is taken at once.
        out_ready = 1'b1;
        send(F_DIV, 1'b0, 64'd999, 64'd7, 5'h10);
        repeat (19) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        check(busy === 1'b0, "flush_calc_busy", {63'd0, busy}, 64'd0);
        run(F_MULHU, 1'b0, 64'hDEAD_BEEF_0000_1234, 64'h0000_0000_ABCD_0001, 5'h11, 0);

        // Flush beats out_ready in DONE.
        out_ready = 1'b0;
        send(F_DIVU, 1'b0, 64'd55, 64'd0, 5'h12);
        wait_valid(lat);
        check(lat == 1, "fast_latency", 64'(lat), 64'd1);
        step();
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        check(out_valid === 1'b0, "flush_done_drop", {63'd0, out_valid}, 64'd0);

        // Flush in IDLE blocks acceptance.
        in_valid = 1'b1; in_func3 = F_MUL; in_is_word = 1'b0;
        in_data1 = 64'd3; in_data2 = 64'd4; in_tag = 5'h13;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check(busy === 1'b0, "flush_idle_block", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-calculation.
        send(F_DIV, 1'b0, 64'd100, 64'd7, 5'h14);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(busy === 1'b0, "async_reset_busy", {63'd0, busy}, 64'd0);
        check(out_valid === 1'b0, "async_reset_valid", {63'd0, out_valid}, 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        check(in_ready === 1'b1, "ready_after_async", {63'd0, in_ready}, 64'd1);
        run(F_DIV, 1'b0, 64'd10, 64'd3, 5'h15, 0);
        pin("pin_div10_3", F_DIV, 1'b0, 64'd10, 64'd3, 64'd3);

        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run(f, w, a, b, 5'($urandom), int'($urandom_range(0, 3)));
        end

        check(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV64M multiply/divide unit that executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the RV64 word forms MULW/DIVW/DIVUW/REMW/REMUW.
- Sits beside the combinational integer ALU in the execute stage.
- Instructions with func7 = 0000001 are steered here and retire through a valid/ready result port.
- Generalises integer M-extension arithmetic to a parametrised width with iterative datapaths, correct RISC-V divide-by-zero/overflow semantics, op tagging and flush.

Parameters:
- DATA_WIDTH, 64, operand/result width.
- WORD_LENGTH, 32, width of the *W operations; must be < DATA_WIDTH.
- TAG_WIDTH, 5, width of the opaque tag (destination register id) carried from request to result.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of the in-flight op.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- in_func3  input  3  M-extension func3.
- in_is_word  input  1  1 = opcode 0111011 (*W form).
- in_data1  input  DATA_WIDTH  rs1 value.
- in_data2  input  DATA_WIDTH  rs2 value.
- in_tag  input  TAG_WIDTH  tag returned with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_res  output  DATA_WIDTH  result.
- out_tag  output  TAG_WIDTH  tag of the result.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - out_valid, out_res, out_tag, busy, iteration counter all 0.
  - in_ready = 1 once reset is deasserted.
- States and transitions:
  - IDLE: in_ready = 1. On in_valid at an edge, latch operands, op and tag. Go to DONE if a fast-path case applies, else to CALC.
  - CALC: one radix-2 iteration per cycle. After N iterations go to DONE. N = DATA_WIDTH, or WORD_LENGTH when in_is_word = 1.
  - DONE: out_valid = 1, outputs stable. On out_ready at an edge go to IDLE.
  - in_ready = 0 outside IDLE. There is no back-to-back overlap: the next request is accepted no earlier than the edge after the result handshake.
- Latency, counted from the accepting edge to the first cycle out_valid = 1:
  - normal ops: N + 1 edges (DATA_WIDTH = 64 gives 65; W ops give 33).
  - fast path: 1 edge.
- Multiply:
  - Shift-add on operand magnitudes into a 2·DATA_WIDTH accumulator.
  - Final two's-complement negate when the sign of the product is negative:
    - MULH: both operands signed.
    - MULHSU: data1 signed, data2 unsigned.
    - MULHU / MUL: no sign correction required for the bits returned.
  - MUL returns the low DATA_WIDTH bits; MULH/MULHSU/MULHU return the high DATA_WIDTH bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient negated if the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Word ops:
  - Operands are the low WORD_LENGTH bits, sign- or zero-extended per op.
  - The WORD_LENGTH-bit result is sign-extended to DATA_WIDTH, including DIVUW/REMUW.
  - MULW = low WORD_LENGTH bits of the product, sign-extended.
- Fast path (no CALC cycles):
  - Divisor = 0: DIV/DIVU quotient = all ones; REM/REMU = dividend. Word forms apply the same rule at WORD_LENGTH, then sign-extend.
  - Signed overflow (dividend = most-negative, divisor = -1): DIV quotient = dividend; REM = 0. Same rule for the word forms.
  - in_is_word = 1 with func3 in {001, 010, 011} (no W form exists): out_res = 0.
- Flush:
  - flush = 1 at an edge in CALC or DONE: state → IDLE, out_valid = 0, no result is produced.
  - flush in IDLE also blocks acceptance that cycle; flush has priority over in_valid.
  - flush in DONE with out_ready = 1: the result is dropped (flush wins).
- Reset mid-operation: abandons the op immediately; no result is ever produced.
- Outputs are registered. out_res/out_tag hold their value while out_valid = 1 and out_ready = 0.

Decomposition:
- Shared package muldiv_pkg holds:
  - typedef enum for func3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - typedef enum state_t {IDLE, CALC, DONE}.
  - constants OPC_OP = 7'b0110011, OPC_OP32 = 7'b0111011, FUNC7_MULDIV = 7'b0000001.
- One natural sub-module: muldiv_sign_ctl (combinational). Computes operand magnitudes, the negate-result flag and the fast-path detect/value. The top level keeps the FSM, counter and shared accumulator/remainder registers.

Test Plan:
- MUL 7 × -3 (DATA_WIDTH = 64), out_ready = 1 → out_res = 0xFFFFFFFFFFFFFFEB; out_valid rises 65 edges after acceptance; out_tag echoes in_tag = 5'h0A.
- MULH 0x8000000000000000 × 0x8000000000000000 → 0x4000000000000000. MULHU 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULHSU -1 × 2 → 0xFFFFFFFFFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFFFFFFFFFD. REM -7 / 2 → 0xFFFFFFFFFFFFFFFF. DIVU 100 / 0 → all ones after 1 edge. REM 0x8000000000000000 / -1 → 0 after 1 edge.
- DIVUW data1 = 0x00000000_FFFFFFFE, data2 = 1 → 0xFFFFFFFFFFFFFFFE after 33 edges. ADDW-style extension check: MULW 0x7FFFFFFF × 2 → 0xFFFFFFFFFFFFFFFE.
- Backpressure/flush:
  - Hold out_ready = 0 for 10 cycles → out_res stable and in_ready = 0 throughout; completes on out_ready.
  - flush during CALC at iteration 20 → no out_valid; next request accepted the following cycle and returns the correct result.
- Reset: drop rst_n asynchronously mid-CALC → out_valid = 0 immediately; after release in_ready = 1 and a DIV 10 / 3 → 3.
